// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel-rate divider, h/v counters and
// decoded sync/blank/marker outputs, all combinational from the counters.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] Q_X,
  output logic [9:0] Q_Y,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank_n,
  output logic       sync_n,
  output logic       vga_clk,
  output logic       pix_en,
  output logic       frame_start,
  output logic       line_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // Sync windows compared in 11 bits so a 1024-wide total cannot overflow.
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end
    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be even and >= 2");
    end
  endgenerate

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h;
  logic [9:0]       r_v;

  logic [DIV_W-1:0] w_div_next;
  logic [9:0]       w_h_next;
  logic [9:0]       w_v_next;
  logic             w_pix_en;
  logic             w_line_end;
  logic             w_frame_end;
  logic [10:0]      w_h_ext;
  logic [10:0]      w_v_ext;

  assign w_pix_en    = (r_div == DIV_LAST);
  assign w_line_end  = w_pix_en && (r_h == H_LAST);
  assign w_frame_end = w_line_end && (r_v == V_LAST);
  assign w_h_ext     = {1'b0, r_h};
  assign w_v_ext     = {1'b0, r_v};

  always_comb begin
    w_div_next = w_pix_en ? '0 : r_div + DIV_W'(1);
    w_h_next   = r_h;
    w_v_next   = r_v;
    if (w_pix_en) begin
      w_h_next = (r_h == H_LAST) ? 10'd0 : r_h + 10'd1;
    end
    if (w_line_end) begin
      w_v_next = (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
    end
  end

  // Reset abandons any partial line; the raster restarts at (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_div_next;
      r_h   <= w_h_next;
      r_v   <= w_v_next;
    end
  end

  assign Q_X         = r_h;
  assign Q_Y         = r_v;
  assign pix_en      = w_pix_en;
  assign vga_clk     = (r_div >= DIV_HALF);
  assign line_end    = w_line_end;
  assign frame_start = w_frame_end;
  assign hsync_n     = !((w_h_ext >= HS_BEG) && (w_h_ext < HS_END));
  assign vsync_n     = !((w_v_ext >= VS_BEG) && (w_v_ext < VS_END));
  assign blank_n     = (w_h_ext < H_ACT) && (w_v_ext < V_ACT);
  assign sync_n      = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: per-cycle check of three instances against an
// elapsed-clock raster model, plus hand-computed directed expectations.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_clk = 0;       // clocks since the last reset edge
  logic cmp_en = 1'b0;

  // Default instance
  logic [9:0] x0, y0;
  logic hs0, vs0, bl0, sy0, vc0, pe0, fs0, le0;
  vga_timing_gen u_d0 (
    .clk(clk), .rst_n(rst_n), .Q_X(x0), .Q_Y(y0), .hsync_n(hs0), .vsync_n(vs0),
    .blank_n(bl0), .sync_n(sy0), .vga_clk(vc0), .pix_en(pe0),
    .frame_start(fs0), .line_end(le0));

  // CLK_DIV=4 instance
  logic [9:0] x4, y4;
  logic hs4, vs4, bl4, sy4, vc4, pe4, fs4, le4;
  vga_timing_gen #(.CLK_DIV(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .Q_X(x4), .Q_Y(y4), .hsync_n(hs4), .vsync_n(vs4),
    .blank_n(bl4), .sync_n(sy4), .vga_clk(vc4), .pix_en(pe4),
    .frame_start(fs4), .line_end(le4));

  // Shrunken raster (16x9 totals) so whole frames fit in a short run
  logic [9:0] xs, ys;
  logic hss, vss, bls, sys, vcs, pes, fss, les;
  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)) u_sm (
    .clk(clk), .rst_n(rst_n), .Q_X(xs), .Q_Y(ys), .hsync_n(hss), .vsync_n(vss),
    .blank_n(bls), .sync_n(sys), .vga_clk(vcs), .pix_en(pes),
    .frame_start(fss), .line_end(les));

  // Expected outputs after n clocks since reset, from raster arithmetic.
  function automatic logic [27:0] model(int n, int d, int ha, int hf, int hsw, int hb,
                                        int va, int vf, int vsw, int vb);
    int ht, vt, dv, pix, h, v;
    logic pe, vc, le, fs, hs, vs, bl;
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    dv  = n % d;
    pix = n / d;
    h   = pix % ht;
    v   = (pix / ht) % vt;
    pe  = (dv == d - 1);
    vc  = (dv >= d / 2);
    le  = pe && (h == ht - 1);
    fs  = le && (v == vt - 1);
    hs  = !((h >= ha + hf) && (h < ha + hf + hsw));
    vs  = !((v >= va + vf) && (v < va + vf + vsw));
    bl  = (h < ha) && (v < va);
    return {10'(h), 10'(v), hs, vs, bl, 1'b0, vc, pe, fs, le};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d (clk %0d)", name, act, req, n_clk);
    end
  endtask

  task automatic chk_vec(input string name, input logic [27:0] act, input logic [27:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (clk %0d)", name, act, req, n_clk);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      n_clk  <= 0;
      cmp_en <= 1'b1;
    end else begin
      n_clk <= n_clk + 1;
    end
  end

  // Run-length monitors
  int hl0 = 0, vls = 0, vc_len = 0, fs_cnt = 0;
  logic vc_prev = 1'b0, vc_valid = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk_vec("raster_d0", {x0, y0, hs0, vs0, bl0, sy0, vc0, pe0, fs0, le0},
              model(n_clk, 2, 640, 16, 96, 48, 480, 10, 2, 33));
      chk_vec("raster_d4", {x4, y4, hs4, vs4, bl4, sy4, vc4, pe4, fs4, le4},
              model(n_clk, 4, 640, 16, 96, 48, 480, 10, 2, 33));
      chk_vec("raster_small", {xs, ys, hss, vss, bls, sys, vcs, pes, fss, les},
              model(n_clk, 2, 8, 2, 3, 3, 4, 1, 2, 2));
    end
    if (!rst_n) begin
      hl0 = 0; vls = 0; vc_len = 0; fs_cnt = 0;
      vc_prev = 1'b0; vc_valid = 1'b0;
    end else if (cmp_en) begin
      if (!hs0) hl0++;
      else if (hl0 != 0) begin chk("hsync_low_clks_d0", hl0, 192); hl0 = 0; end
      if (!vss) vls++;
      else if (vls != 0) begin chk("vsync_low_clks_small", vls, 64); vls = 0; end
      if (fss) fs_cnt++;
      if (vc4 != vc_prev) begin
        if (vc_valid) chk(vc_prev ? "vga_clk_high_clks_d4" : "vga_clk_low_clks_d4", vc_len, 2);
        vc_valid = 1'b1;
        vc_len   = 1;
        vc_prev  = vc4;
      end else begin
        vc_len++;
      end
    end
  end

  task automatic adv_to(input int target);
    while (n_clk < target) @(negedge clk);
  endtask

  task automatic note(input string name, input int act);
    $display("check %-22s clk=%0d value=%0d", name, n_clk, act);
  endtask

  initial begin
    logic found;
    // Reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_qx", int'(x0), 0);
      chk("reset_qy", int'(y0), 0);
      chk("reset_syncs", int'({hs0, vs0, bl0}), 7);
      chk("reset_vgaclk_fs", int'({vc0, fs0, pe0}), 0);
      note("reset", i);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    adv_to(1);    chk("first_pix_en", int'(pe0), 1); note("first_pix_en", pe0);
    adv_to(20);   chk("qx_at_20", int'(x0), 10); note("qx_at_20", x0);
    adv_to(287);  chk("small_fs_pos", int'({fss, xs, ys}), (1 << 20) | (15 << 10) | 8);
                  note("small_frame_start", fss);
    adv_to(288);  chk("small_wrap_00", int'({xs, ys}), 0);
                  chk("small_fs_count", fs_cnt, 1); note("small_fs_count", fs_cnt);
    adv_to(1279); chk("blank_at_639", int'(bl0), 1);
    adv_to(1280); chk("blank_at_640", int'(bl0), 0); note("blank_fall", x0);
    adv_to(1311); chk("hsync_at_655", int'(hs0), 1);
    adv_to(1312); chk("hsync_at_656", int'(hs0), 0); note("hsync_fall", x0);
    adv_to(1503); chk("hsync_at_751", int'(hs0), 0);
    adv_to(1504); chk("hsync_at_752", int'(hs0), 1); note("hsync_rise", x0);
    adv_to(1599); chk("line_end_799", int'({le0, x0}), (1 << 10) | 799); note("line_end_d0", le0);
    adv_to(1600); chk("next_line_d0", int'({x0, y0}), 1); note("next_line_d0", y0);
    adv_to(3199); chk("line_end_d4", int'({le4, x4}), (1 << 10) | 799); note("line_end_d4", le4);
    adv_to(3200); chk("next_line_d4", int'({x4, y4}), 1); note("next_line_d4", y4);

    // Mid-frame reset at (300,2) on the default instance
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (x0 == 10'd300 && y0 == 10'd2) found = 1'b1;
    end
    chk("reach_300_2", int'(found), 1); note("mid_frame_reached", found);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_qx", int'(x0), 0);
    chk("midreset_qy", int'(y0), 0); note("mid_reset", x0);
    adv_to(1);  chk("post_reset_pix_en", int'(pe0), 1);
    adv_to(20); chk("post_reset_qx_20", int'(x0), 10); note("post_reset_qx_20", x0);
    adv_to(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480@60 Hz VGA raster that drives all sprite ROMs and the DAC. It divides the 50 MHz system clock into a pixel enable and a DAC pixel clock. It also runs the horizontal and vertical counters, whose values go out as the `Q_X`/`Q_Y` pixel coordinates consumed by every sprite block. The same counters are decoded into active-low sync, blank and frame/line markers. Sprite blocks decode `Q_X`/`Q_Y` combinationally, and the RGB mux after them feeds the DAC clocked by `vga_clk`.

## Interface
Parameters:
- `CLK_DIV`, 2, system clocks per pixel; even, ≥2
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch, pixels
- `H_SYNC`, 96, horizontal sync width, pixels
- `H_BP`, 48, horizontal back porch, pixels
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch, lines
- `V_SYNC`, 2, vertical sync width, lines
- `V_BP`, 33, vertical back porch, lines

Ports:
- One clock; reset is synchronous and active-low.
- `clk`  in  1  system clock, 50 MHz
- `rst_n`  in  1  synchronous active-low reset
- `Q_X`  out  10  horizontal counter, 0..H_TOTAL-1
- `Q_Y`  out  10  vertical counter, 0..V_TOTAL-1
- `hsync_n`  out  1  horizontal sync, active low
- `vsync_n`  out  1  vertical sync, active low
- `blank_n`  out  1  1 inside the active area
- `sync_n`  out  1  DAC composite sync, constant 0
- `vga_clk`  out  1  DAC pixel clock, clk/CLK_DIV
- `pix_en`  out  1  1-clk strobe, one per pixel
- `frame_start`  out  1  1-clk pulse, last pixel of the frame
- `line_end`  out  1  1-clk pulse, last pixel of each line

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Both totals must be ≤1024; an elaboration-time check enforces this.
- Divider:
  - `div_cnt` runs 0..CLK_DIV-1 and wraps.
  - `pix_en` = (div_cnt == CLK_DIV-1).
  - `vga_clk` = (div_cnt ≥ CLK_DIV/2).
- Horizontal counter `h` advances only on a clock edge where pix_en=1. At H_TOTAL-1 it wraps to 0.
- Vertical counter `v` advances only on a clock edge where pix_en=1 and h=H_TOTAL-1. At V_TOTAL-1 it wraps to 0.
- `Q_X` = h and `Q_Y` = v; both come straight from the registers, with no decode.
- `hsync_n` = 0 iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, i.e. pixels 656..751.
- `vsync_n` = 0 iff V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, i.e. lines 490..491.
- `blank_n` = (h < H_ACTIVE) && (v < V_ACTIVE).
- `line_end` = pix_en && h == H_TOTAL-1.
- `frame_start` = line_end && v == V_TOTAL-1. It marks the cycle immediately before the counters reach (0,0).
- Sprite position and game-state updates are clocked on this pulse.
- All decoded outputs are combinational functions of the registers, so they stay aligned to `Q_X`/`Q_Y` with zero skew.

## Timing
- Reset applies at the rising `clk` edge with rst_n=0. Registers go to div_cnt=0, h=0, v=0.
- Resulting output values during reset:
  - `Q_X`=0, `Q_Y`=0
  - `vga_clk`=0, `pix_en`=0 (for CLK_DIV≥2)
  - `hsync_n`=1, `vsync_n`=1, `blank_n`=1
  - `line_end`=0, `frame_start`=0, `sync_n`=0
- Reset asserted mid-frame, at any h/v/div_cnt: state is zeroed on the next edge; there is no partial-line completion.
- After rst_n rises, the first `pix_en` is at clock CLK_DIV-1. `Q_X` reaches N after exactly N·CLK_DIV clock edges.
- `Q_X`/`Q_Y` change only on the edge where `vga_clk` falls (div_cnt wraps to 0). This gives the DAC half a pixel period of setup before the `vga_clk` rising edge.
- Simultaneous h and v wrap, at (799,524) with pix_en: both go to 0 on the same edge.
- `frame_start` and `line_end` are both high in that cycle.
- Timing at CLK_DIV=2:
  - Line = 1600 clocks; frame = 840 000 clocks (59.52 Hz).
  - hsync low for 192 consecutive clocks; vsync low for 3200 consecutive clocks.

## Test plan
- Reset: hold rst_n=0 for 5 cycles. Require `Q_X`=0, `Q_Y`=0, `hsync_n`=1, `vsync_n`=1, `blank_n`=1, `vga_clk`=0, `frame_start`=0 throughout.
- Pixel cadence: release reset and count edges.
  - `vga_clk` toggles every clock.
  - `pix_en` is high on odd clocks only.
  - `Q_X`=10 exactly 20 edges after release.
- Horizontal line: run one full line.
  - `hsync_n` falls when `Q_X` goes 655→656 and rises at 751→752 (192 clocks low).
  - `blank_n` falls at 639→640.
  - At `Q_X`=799 with pix_en, `line_end`=1; next edge gives `Q_X`=0, `Q_Y`=1.
- Vertical frame: run 840 000 clocks.
  - `vsync_n` is low only for `Q_Y`=490 and 491 (3200 clocks).
  - `blank_n`=0 for all `Q_Y`≥480.
  - Exactly one `frame_start` pulse, at (799,524); next edge gives (0,0).
- Reset mid-frame: at `Q_X`=300, `Q_Y`=200, drive rst_n=0 for 1 cycle. Next edge gives `Q_X`=0, `Q_Y`=0; after release, cadence matches the second scenario.
- Parameter override: CLK_DIV=4. Require `vga_clk` high for 2 and low for 2 clocks, `pix_en` every 4th clock, and line = 3200 clocks.
